// File: rtl/sr_pkg.sv
// Shared definitions for the sr set/reset cell bank.
// The {lo,hi} operation decode is used by the RTL and by the bench.
package sr_pkg;

  // Stored value after reset and after a conflict resolves (reset-dominant).
  localparam logic SR_RESET_STATE = 1'b0;

  // Encoding equals {lo,hi}, so a decode is a plain cast.
  typedef enum logic [1:0] {
    SR_HOLD     = 2'b00,
    SR_SET      = 2'b01,
    SR_RESET    = 2'b10,
    SR_CONFLICT = 2'b11
  } sr_op_e;

  function automatic sr_op_e sr_decode(input logic lo, input logic hi);
    return sr_op_e'({lo, hi});
  endfunction

endpackage

// File: rtl/sr_cell.sv
// Single NOR set/reset cell modelled synchronously.
// Outputs are combinational from the inputs and the stored state; the
// only feedback is through st_q, so no combinational loop exists.
// Optional macro SR_CONFLICT_FLAG_EN adds the per-cell conflict output.
module sr_cell
  import sr_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic s,
  input  logic r,
  input  logic r2,
  output logic q,
  output logic q_bar
`ifdef SR_CONFLICT_FLAG_EN
  ,
  output logic conflict
`endif
);

  logic   st_q;
  logic   q_d;
  logic   q_bar_d;
  sr_op_e op;

  // Resolve the cell outputs for this cycle; reset overrides everything.
  always_comb begin
    op      = sr_decode(s | r2, r);
    q_d     = st_q;
    q_bar_d = ~st_q;
    case (op)
      SR_HOLD: begin
        q_d     = st_q;
        q_bar_d = ~st_q;
      end
      SR_SET: begin
        q_d     = 1'b1;
        q_bar_d = 1'b0;
      end
      SR_RESET: begin
        q_d     = 1'b0;
        q_bar_d = 1'b1;
      end
      SR_CONFLICT: begin
        // Both NOR gates driven: both outputs low.
        q_d     = 1'b0;
        q_bar_d = 1'b0;
      end
      default: begin
        q_d     = st_q;
        q_bar_d = ~st_q;
      end
    endcase
    if (reset) begin
      q_d     = SR_RESET_STATE;
      q_bar_d = ~SR_RESET_STATE;
    end
  end

  assign q     = q_d;
  assign q_bar = q_bar_d;

  // Capture the resolved output as the new stored state.
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q <= SR_RESET_STATE;
    end else begin
      st_q <= q_d;
    end
  end

`ifdef SR_CONFLICT_FLAG_EN
  assign conflict = (op == SR_CONFLICT) & ~reset;
`endif

endmodule

// File: rtl/sr.sv
// Bank of WIDTH independent set/reset cells.
// Optional macro SR_CONFLICT_FLAG_EN adds the per-bit conflict output and
// the sticky conflict_seen flag, cleared only by reset.
module sr
  import sr_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
`ifdef SR_CONFLICT_FLAG_EN
  ,
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_seen
`endif
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      sr_cell u_cell (
        .clock    (clock),
        .reset    (reset),
        .s        (s[gi]),
        .r        (r[gi]),
        .r2       (r2[gi]),
        .q        (q[gi]),
        .q_bar    (q_bar[gi])
`ifdef SR_CONFLICT_FLAG_EN
        ,
        .conflict (conflict[gi])
`endif
      );
    end
  endgenerate

`ifdef SR_CONFLICT_FLAG_EN
  logic conflict_seen_q;

  // Sticky record of any conflict observed at a clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_seen_q <= SR_RESET_STATE;
    end else if (|conflict) begin
      conflict_seen_q <= 1'b1;
    end
  end

  assign conflict_seen = conflict_seen_q;
`endif

endmodule

// File: tb/tb_sr.sv
// Scoreboard bench for sr (WIDTH=4). Stimulus pushes hand-computed
// expectations into a queue; a monitor pops and compares each cycle.
module tb_sr;
  import sr_pkg::*;

  localparam int W = 4;
  localparam int NV = 23;

  logic         clock;
  logic         reset;
  logic [W-1:0] s, r, r2;
  logic [W-1:0] q, q_bar;
`ifdef SR_CONFLICT_FLAG_EN
  logic [W-1:0] conflict;
  logic         conflict_seen;
`endif

  sr #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .s            (s),
    .r            (r),
    .r2           (r2),
    .q            (q),
    .q_bar        (q_bar)
`ifdef SR_CONFLICT_FLAG_EN
    ,
    .conflict     (conflict),
    .conflict_seen(conflict_seen)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic         rst;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] r2;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic [W-1:0] cf;
    logic         seen;
  } vec_t;

  typedef struct {
    int   idx;
    vec_t v;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[NV];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 1'b0;

  // Hand-computed vectors: {rst, s, r, r2, exp q, exp q_bar, exp conflict, exp conflict_seen}
  initial begin
    vecs[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0}; // reset
    vecs[1]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0}; // hold after reset
    vecs[3]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0};
    vecs[4]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0};
    vecs[5]  = '{1'b0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0}; // set
    vecs[6]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0}; // reset via s
    vecs[7]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0}; // hold
    vecs[8]  = '{1'b0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0}; // set
    vecs[9]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0}; // hold high
    vecs[10] = '{1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0}; // r2 pulse
    vecs[11] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0}; // hold low
    vecs[12] = '{1'b0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0}; // set
    vecs[13] = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0}; // conflict
    vecs[14] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1}; // release -> low
    vecs[15] = '{1'b0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1}; // set
    vecs[16] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1}; // hold high
    vecs[17] = '{1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1}; // reset mid-set
    vecs[18] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0}; // state cleared
    vecs[19] = '{1'b0, 4'h1, 4'h6, 4'h0, 4'h6, 4'h9, 4'h0, 1'b0}; // per-bit mix
    vecs[20] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h6, 4'h9, 4'h0, 1'b0}; // hold
    vecs[21] = '{1'b0, 4'h0, 4'h0, 4'h4, 4'h2, 4'hD, 4'h0, 1'b0}; // r2 on bit 2
    vecs[22] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h2, 4'hD, 4'h0, 1'b0}; // hold
  end

  // Stimulus: drive one vector per cycle just after the rising edge.
  initial begin
    reset = 1'b1;
    s     = '0;
    r     = '0;
    r2    = '0;
    for (int i = 0; i < NV; i++) begin
      exp_t e;
      @(posedge clock);
      #1;
      reset = vecs[i].rst;
      s     = vecs[i].s;
      r     = vecs[i].r;
      r2    = vecs[i].r2;
      e.idx = i;
      e.v   = vecs[i];
      exp_q.push_back(e);
    end
    begin
      int budget;
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
        @(posedge clock);
        budget--;
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: pending=%0d required=0", exp_q.size());
      end
    end
    done = 1'b1;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: outputs are valid every cycle; sample on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (done) break;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        $display("vec %0d rst=%b s=%h r=%h r2=%h -> q=%h q_bar=%h",
                 e.idx, e.v.rst, e.v.s, e.v.r, e.v.r2, q, q_bar);
        checks++;
        if (q !== e.v.q) begin
          errors++;
          $display("FAIL q[%0d]: got=%h want=%h", e.idx, q, e.v.q);
        end
        checks++;
        if (q_bar !== e.v.qb) begin
          errors++;
          $display("FAIL q_bar[%0d]: got=%h want=%h", e.idx, q_bar, e.v.qb);
        end
`ifdef SR_CONFLICT_FLAG_EN
        checks++;
        if (conflict !== e.v.cf) begin
          errors++;
          $display("FAIL conflict[%0d]: got=%h want=%h", e.idx, conflict, e.v.cf);
        end
        checks++;
        if (conflict_seen !== e.v.seen) begin
          errors++;
          $display("FAIL conflict_seen[%0d]: got=%b want=%b", e.idx, conflict_seen, e.v.seen);
        end
`endif
      end
    end
  end

endmodule
